multi_led_blinker: RTL and testbench

Parametrised, multi-channel successor to the single-channel timer + LED blinker pair. Contains one shared tick prescaler and CH independent channel engines. Each channel runs in one of four modes: off, on, free-running blink, or a counted burst with a start/busy/done handshake. The block sits between control registers or switches and board LEDs.

---
 rtl/multi_led_pkg.sv | 22 ++
 rtl/led_channel.sv | 122 ++++++++++++
 rtl/multi_led_blinker.sv | 64 ++++++
 tb/tb_multi_led_blinker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_led_pkg.sv
// Shared types for the multi-channel LED blinker: channel modes and burst FSM states.
package multi_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ON   = 2'b01,
      ST_OFF  = 2'b10
   } burst_st_t;

   // LED level a channel shows right after entering a mode.
   function automatic logic mode_init_led(input mode_t m);
      return (m == MODE_ON);
   endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: tick counter, mode-change tracking, burst FSM and registered outputs.
module led_channel
   import multi_led_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               tick,
   input  logic [1:0]         mode,
   input  logic [CNT_W-1:0]   n,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               start,
   output logic               led,
   output logic               busy,
   output logic               done
);

   mode_t               mode_cur;
   mode_t               mode_q;
   burst_st_t           state, state_d;
   logic [CNT_W-1:0]    tcnt, tcnt_d;
   logic [CNT_W-1:0]    n_last;
   logic [BURST_W-1:0]  rem, rem_d;
   logic                led_d, done_d;
   logic                mode_chg;
   logic                phase_end;

   assign mode_cur  = mode_t'(mode);
   assign mode_chg  = (mode_cur != mode_q);
   // n=0 behaves as n=1; >= lets a live decrease of n end the phase on the next tick.
   assign n_last    = (n == '0) ? '0 : n - CNT_W'(1);
   assign phase_end = tick && (tcnt >= n_last);

   always_comb begin
      // NOTE: every signal gets its default first, so no path leaves one unassigned and no latch is inferred.
      tcnt_d  = tcnt;
      state_d = state;
      rem_d   = rem;
      led_d   = led;
      done_d  = 1'b0;

      if (mode_chg) begin
         tcnt_d  = '0;
         state_d = ST_IDLE;
         led_d   = mode_init_led(mode_cur);
      end else begin
         if (tick) begin
            tcnt_d = phase_end ? '0 : tcnt + CNT_W'(1);
         end
         case (mode_cur)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: if (phase_end) led_d = ~led;
            MODE_BURST: begin
               case (state)
                  ST_IDLE: begin
                     led_d = 1'b0;
                     if (start) begin
                        if (burst_len != '0) begin
                           rem_d   = burst_len;
                           tcnt_d  = '0;
                           state_d = ST_ON;
                           led_d   = 1'b1;
                        end else begin
                           done_d = 1'b1;
                        end
                     end
                  end
                  ST_ON: begin
                     if (phase_end) begin
                        state_d = ST_OFF;
                        led_d   = 1'b0;
                     end
                  end
                  ST_OFF: begin
                     if (phase_end) begin
                        rem_d = rem - BURST_W'(1);
                        if (rem == BURST_W'(1)) begin
                           state_d = ST_IDLE;
                           done_d  = 1'b1;
                        end else begin
                           state_d = ST_ON;
                           led_d   = 1'b1;
                        end
                     end
                  end
                  default: state_d = ST_IDLE;
               endcase
            end
            default: led_d = 1'b0;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= MODE_OFF;
         state  <= ST_IDLE;
         tcnt   <= '0;
         rem    <= '0;
         led    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (en) begin
         mode_q <= mode_cur;
         state  <= state_d;
         tcnt   <= tcnt_d;
         rem    <= rem_d;
         led    <= led_d;
         busy   <= (state_d != ST_IDLE);
         done   <= done_d;
      end else begin
         // Frozen: everything holds except the done strobe.
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker: one shared tick prescaler driving CH independent channel engines.
module multi_led_blinker
   import multi_led_pkg::*;
#(
   parameter int CH       = 4,
   parameter int CNT_W    = 16,
   parameter int BURST_W  = 8,
   parameter int TICK_DIV = 100000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [2*CH-1:0]        mode,
   input  logic [CNT_W*CH-1:0]    n,
   input  logic [BURST_W*CH-1:0]  burst_len,
   input  logic [CH-1:0]          start,
   output logic [CH-1:0]          led,
   output logic [CH-1:0]          busy,
   output logic [CH-1:0]          done,
   output logic                   tick
);

   localparam int             PW    = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else if (en) begin
         if (pcnt == PLAST) begin
            pcnt <= '0;
            tick <= 1'b1;
         end else begin
            pcnt <= pcnt + PW'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      led_channel #(
         .CNT_W   (CNT_W),
         .BURST_W (BURST_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .tick      (tick),
         .mode      (mode[2*i +: 2]),
         .n         (n[CNT_W*i +: CNT_W]),
         .burst_len (burst_len[BURST_W*i +: BURST_W]),
         .start     (start[i]),
         .led       (led[i]),
         .busy      (busy[i]),
         .done      (done[i])
      );
   end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed bench for multi_led_blinker: expected per-cycle outputs queued as stimulus is planned, checked at negedge.
module tb_multi_led_blinker;

   localparam int CH       = 4;
   localparam int CNT_W    = 8;
   localparam int BURST_W  = 4;
   localparam int TICK_DIV = 4;

   localparam int F_LED  = 0;
   localparam int F_BUSY = 1;
   localparam int F_DONE = 2;
   localparam int F_TICK = 3;

   typedef struct {
      int   cyc;
      int   ch;
      int   fld;
      logic val;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  en  = 1'b0;
   logic [2*CH-1:0]       mode = '0;
   logic [CNT_W*CH-1:0]   n = '0;
   logic [BURST_W*CH-1:0] burst_len = '0;
   logic [CH-1:0]         start = '0;
   logic [CH-1:0]         led, busy, done;
   logic                  tick;

   int   cyc   = 0;
   int   base  = 0;
   int   n_cmp = 0;
   int   n_mis = 0;
   exp_t sb[$];

   multi_led_blinker #(
      .CH       (CH),
      .CNT_W    (CNT_W),
      .BURST_W  (BURST_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .mode      (mode),
      .n         (n),
      .burst_len (burst_len),
      .start     (start),
      .led       (led),
      .busy      (busy),
      .done      (done),
      .tick      (tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic string fname(input int f);
      case (f)
         F_LED:   return "led";
         F_BUSY:  return "busy";
         F_DONE:  return "done";
         default: return "tick";
      endcase
   endfunction

   function automatic logic observe(input int ch, input int f);
      case (f)
         F_LED:   return led[ch];
         F_BUSY:  return busy[ch];
         F_DONE:  return done[ch];
         default: return tick;
      endcase
   endfunction

   task automatic push(input int c, input int ch, input int f, input logic v);
      exp_t e;
      e.cyc = c;
      e.ch  = ch;
      e.fld = f;
      e.val = v;
      sb.push_back(e);
   endtask

   // First cycle >= c at which tick is visible, with ticks every TICK_DIV cycles after base.
   function automatic int next_tick(input int c);
      int t = c;
      while (((t - base) % TICK_DIV) != 0) t++;
      return t;
   endfunction

   // Cycle at which a phase whose counter cleared at cycle p ends, for half-period nv.
   function automatic int phase_end_at(input int p, input int nv);
      int m = (nv == 0) ? 1 : nv;
      return next_tick(p) + TICK_DIV * (m - 1) + 1;
   endfunction

   task automatic expect_blink(input int ch, input int p, input int nv, input int toggles);
      int   e = p;
      logic v = 1'b0;
      for (int i = 0; i < toggles; i++) begin
         e = phase_end_at(e, nv);
         push(e - 1, ch, F_LED, v);
         push(e, ch, F_LED, ~v);
         v = ~v;
      end
   endtask

   task automatic set_mode(input int ch, input logic [1:0] m);
      mode[2*ch +: 2] = m;
   endtask

   task automatic set_n(input int ch, input int nv);
      n[CNT_W*ch +: CNT_W] = CNT_W'(nv);
   endtask

   task automatic set_bl(input int ch, input int bl);
      burst_len[BURST_W*ch +: BURST_W] = BURST_W'(bl);
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check($sformatf("c%0d_ch%0d_%s", cyc, sb[i].ch, fname(sb[i].fld)),
                  32'(observe(sb[i].ch, sb[i].fld)), 32'(sb[i].val));
            sb.delete(i);
         end
      end
   end

   initial begin
      int e;
      logic v;

      // Reset state
      #1 rst = 1'b0;
      goto(2);
      check("rst_led",  32'(led),  32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_tick", 32'(tick), 32'(0));

      // Release with en=1: first tick on the 4th enabled edge
      goto(3);
      rst  = 1'b1;
      en   = 1'b1;
      base = 3;
      for (int c = 4; c <= 6; c++) push(c, 0, F_TICK, 1'b0);
      push(7, 0, F_TICK, 1'b1);
      push(8, 0, F_TICK, 1'b0);
      push(11, 0, F_TICK, 1'b1);

      set_n(0, 3);
      set_n(1, 0);
      set_n(2, 2); set_bl(2, 3);
      set_n(3, 1); set_bl(3, 2);

      // Blink ch0 n=3 and ch1 n=0, static on ch3, all entered at cycle 12
      expect_blink(0, 12, 3, 13);
      expect_blink(1, 12, 0, 20);
      push(11, 3, F_LED, 1'b0);
      push(12, 3, F_LED, 1'b1);

      // Burst on ch2: 3 pulses of 8 clk on / 8 clk off starting at cycle 16
      push(15, 2, F_BUSY, 1'b0);
      push(15, 2, F_LED, 1'b0);
      push(16, 2, F_BUSY, 1'b1);
      push(16, 2, F_LED, 1'b1);
      e = 16;
      v = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         e = phase_end_at(e, 2);
         push(e - 1, 2, F_LED, v);
         push(e - 1, 2, F_DONE, 1'b0);
         if (i < 6) v = ~v;
         push(e, 2, F_LED, v);
      end
      push(e - 1, 2, F_BUSY, 1'b1);
      push(e, 2, F_BUSY, 1'b0);
      push(e, 2, F_DONE, 1'b1);
      push(e + 1, 2, F_DONE, 1'b0);

      goto(11);
      set_mode(0, 2'b10);
      set_mode(1, 2'b10);
      set_mode(2, 2'b11);
      set_mode(3, 2'b01);
      goto(15);
      start[2] = 1'b1;
      goto(16);
      start[2] = 1'b0;
      // Start while busy and a burst_len change are both ignored
      goto(30);
      start[2] = 1'b1;
      goto(31);
      start[2] = 1'b0;
      goto(35);
      set_bl(2, 1);

      // burst_len=0: immediate done, busy never rises
      push(70, 2, F_DONE, 1'b0);
      push(71, 2, F_DONE, 1'b1);
      push(72, 2, F_DONE, 1'b0);
      push(71, 2, F_BUSY, 1'b0);
      push(72, 2, F_BUSY, 1'b0);
      goto(66);
      set_bl(2, 0);
      goto(70);
      start[2] = 1'b1;
      goto(71);
      start[2] = 1'b0;

      // Held start: burst of 1, restart the clk after done, then abort into blink
      push(80, 2, F_BUSY, 1'b0);
      push(81, 2, F_BUSY, 1'b1);
      push(81, 2, F_LED, 1'b1);
      e = phase_end_at(81, 2);
      push(e - 1, 2, F_LED, 1'b1);
      push(e, 2, F_LED, 1'b0);
      e = phase_end_at(e, 2);
      push(e - 1, 2, F_BUSY, 1'b1);
      push(e - 1, 2, F_DONE, 1'b0);
      push(e, 2, F_BUSY, 1'b0);
      push(e, 2, F_DONE, 1'b1);
      push(e, 2, F_LED, 1'b0);
      push(e + 1, 2, F_DONE, 1'b0);
      push(e + 1, 2, F_BUSY, 1'b1);
      push(e + 1, 2, F_LED, 1'b1);
      push(100, 2, F_BUSY, 1'b1);
      push(100, 2, F_LED, 1'b1);
      push(101, 2, F_BUSY, 1'b0);
      push(101, 2, F_LED, 1'b0);
      for (int c = 101; c <= 116; c++) push(c, 2, F_DONE, 1'b0);
      expect_blink(2, 101, 2, 2);
      goto(80);
      set_bl(2, 1);
      start[2] = 1'b1;
      goto(97);
      start[2] = 1'b0;
      goto(100);
      set_mode(2, 2'b10);

      // start in the same clk as entering burst mode is ignored
      push(120, 3, F_LED, 1'b1);
      push(121, 3, F_LED, 1'b0);
      for (int c = 121; c <= 123; c++) push(c, 3, F_BUSY, 1'b0);
      goto(120);
      set_mode(3, 2'b11);
      start[3] = 1'b1;
      goto(121);
      start[3] = 1'b0;

      // Live decrease of n at tcnt=5 ends the phase on the next tick
      push(132, 1, F_LED, 1'b0);
      push(150, 1, F_LED, 1'b0);
      push(155, 1, F_LED, 1'b0);
      push(156, 1, F_LED, 1'b1);
      push(163, 1, F_LED, 1'b1);
      push(164, 1, F_LED, 1'b0);
      goto(127);
      set_mode(1, 2'b00);
      goto(131);
      set_mode(1, 2'b10);
      set_n(1, 10);
      goto(152);
      set_n(1, 2);

      // en low for 20 clk: outputs frozen, no tick, no done; timing resumes from frozen tcnt
      for (int c = 169; c <= 199; c++) push(c, 0, F_LED, 1'b1);
      push(200, 0, F_LED, 1'b0);
      for (int c = 173; c <= 194; c++) push(c, 0, F_TICK, 1'b0);
      push(195, 0, F_TICK, 1'b1);
      for (int c = 173; c <= 192; c++) begin
         for (int ch = 0; ch < CH; ch++) push(c, ch, F_DONE, 1'b0);
      end
      for (int c = 181; c <= 192; c++) begin
         push(c, 3, F_LED, 1'b0);
         push(c, 3, F_BUSY, 1'b0);
      end
      push(193, 3, F_LED, 1'b1);
      goto(172);
      en = 1'b0;
      goto(180);
      set_mode(3, 2'b01);
      goto(192);
      en = 1'b1;

      // Async reset mid-burst
      push(207, 3, F_LED, 1'b1);
      for (int c = 207; c <= 209; c++) push(c, 3, F_BUSY, 1'b1);
      goto(205);
      set_mode(3, 2'b11);
      goto(206);
      start[3] = 1'b1;
      goto(207);
      start[3] = 1'b0;
      goto(210);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_led",  32'(led),  32'(0));
      check("async_rst_busy", 32'(busy), 32'(0));
      check("async_rst_done", 32'(done), 32'(0));
      check("async_rst_tick", 32'(tick), 32'(0));

      goto(213);
      rst  = 1'b1;
      base = 213;
      for (int c = 214; c <= 216; c++) push(c, 0, F_TICK, 1'b0);
      push(217, 0, F_TICK, 1'b1);
      push(218, 0, F_TICK, 1'b0);
      push(214, 3, F_BUSY, 1'b0);
      push(215, 3, F_BUSY, 1'b0);
      expect_blink(0, 214, 3, 1);

      goto(230);
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
